// File: rtl/writeback_stage.sv
// writeback_stage: writeback register, 2-read/1-write register file with bypass,
// fetch PC and retired-instruction counter.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W = 32,
  parameter int REG_AW = 3,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic [DATA_W-1:0] mmuxout,
  input  logic              regwrite,
  input  logic [REG_AW-1:0] wbaddr,
  input  logic [PC_W-1:0]   PC_in,
  input  logic [REG_AW-1:0] rd1addr,
  input  logic [REG_AW-1:0] rd2addr,
  output logic [DATA_W-1:0] reg1data,
  output logic [DATA_W-1:0] reg2data,
  output logic [PC_W-1:0]   PC,
  output logic              wb_valid,
  output logic [15:0]       retired
);
  localparam int NREG = 1 << REG_AW;
  logic [DATA_W-1:0] r_rf [NREG];
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_AW-1:0] r_wb_addr;
  logic              r_wb_we;
  logic              r_wb_valid;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_retired;
  logic              w_commit;
  assign w_commit = r_wb_valid && r_wb_we && r_wb_addr != '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_wb_data  <= '0;
      r_wb_addr  <= '0;
      r_wb_we    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_pc       <= PC_RESET;
      r_retired  <= '0;
    end else if (!stall) begin
      if (w_commit) r_rf[r_wb_addr] <= r_wb_data;
      r_wb_valid <= valid_in;
      if (valid_in) begin
        r_wb_data <= mmuxout;
        r_wb_addr <= wbaddr;
        r_wb_we   <= regwrite;
        r_pc      <= PC_in;
        r_retired <= r_retired + 16'd1;
      end
    end
  end
  // Register 0 is hard-wired to zero and never bypassed.
  always_comb begin
    reg1data = rd1addr == '0 ? '0 : (w_commit && rd1addr == r_wb_addr ? r_wb_data : r_rf[rd1addr]);
    reg2data = rd2addr == '0 ? '0 : (w_commit && rd2addr == r_wb_addr ? r_wb_data : r_rf[rd2addr]);
  end
  assign PC       = r_pc;
  assign wb_valid = r_wb_valid;
  assign retired  = r_retired;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench against an architectural register-file model.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst, valid_in, stall, regwrite;
  logic [15:0] mmuxout;
  logic [2:0]  wbaddr, rd1addr, rd2addr;
  logic [31:0] PC_in;
  logic [15:0] reg1data, reg2data, retired;
  logic [31:0] PC;
  logic        wb_valid;
  always #5 clk = ~clk;
  writeback_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .mmuxout(mmuxout),
    .regwrite(regwrite), .wbaddr(wbaddr), .PC_in(PC_in), .rd1addr(rd1addr),
    .rd2addr(rd2addr), .reg1data(reg1data), .reg2data(reg2data), .PC(PC),
    .wb_valid(wb_valid), .retired(retired)
  );
  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] ret;
    logic        wbv;
    logic [15:0] r1;
    logic [15:0] r2;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event async_ev;
  // Architectural state: a capture is visible to reads immediately, whether
  // the hardware serves it from the bypass or from the register file.
  logic [31:0] m_pc;
  logic [15:0] m_ret;
  logic        m_wbv;
  logic [15:0] m_regs [8];
  function automatic exp_t snap(input logic [2:0] a1, input logic [2:0] a2);
    exp_t e;
    e.pc  = m_pc;
    e.ret = m_ret;
    e.wbv = m_wbv;
    e.r1  = a1 == 3'd0 ? 16'h0 : m_regs[a1];
    e.r2  = a2 == 3'd0 ? 16'h0 : m_regs[a2];
    return e;
  endfunction
  task automatic model_reset();
    m_pc = 32'h0;
    m_ret = 16'h0;
    m_wbv = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
  endtask
  task automatic cycle(input logic r, input logic v, input logic s, input logic rw,
                       input logic [2:0] wa, input logic [15:0] d, input logic [31:0] pcin,
                       input logic [2:0] a1, input logic [2:0] a2);
    @(negedge clk);
    rst = r; valid_in = v; stall = s; regwrite = rw; wbaddr = wa;
    mmuxout = d; PC_in = pcin; rd1addr = a1; rd2addr = a2;
    if (!r) model_reset();
    else if (!s) begin
      if (v) begin
        m_pc = pcin;
        m_ret = m_ret + 16'd1;
        m_wbv = 1'b1;
        if (rw && wa != 3'd0) m_regs[wa] = d;
      end else m_wbv = 1'b0;
    end
    q.push_back(snap(a1, a2));
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC", PC, e.pc);
        chk("retired", {16'h0, retired}, {16'h0, e.ret});
        chk("wb_valid", {31'h0, wb_valid}, {31'h0, e.wbv});
        chk("reg1data", {16'h0, reg1data}, {16'h0, e.r1});
        chk("reg2data", {16'h0, reg2data}, {16'h0, e.r2});
      end
    end
  end
  task automatic rand_cycle();
    cycle(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 1'(($urandom)),
          3'($urandom), 16'($urandom), $urandom, 3'($urandom), 3'($urandom));
  endtask
  initial begin
    rst = 1'b0; valid_in = 1'b0; stall = 1'b0; regwrite = 1'b0;
    wbaddr = '0; mmuxout = '0; PC_in = '0; rd1addr = '0; rd2addr = '0;
    model_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h1111, 32'h44, 3'd1, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd1, 3'd2);
    // First capture after reset, bypass then register-file read of r3.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'hBEEF, 32'h10, 3'd3, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd3, 3'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd3, 3'd3);
    // Writes to r0 are discarded and never bypassed.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h1234, 32'h20, 3'd0, 3'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 16'h1234, 32'h24, 3'd0, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd0, 3'd0);
    // Back-to-back captures to r5.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'hAAAA, 32'h30, 3'd5, 3'd5);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h5555, 32'h34, 3'd5, 3'd5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd5, 3'd5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd5, 3'd5);
    // Capture with regwrite=0 retires without writing.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h9999, 32'h38, 3'd5, 3'd5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd5, 3'd5);
    // Stall holds everything, including a pending write.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'hC0DE, 32'h40, 3'd2, 3'd4);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'(i + 4), 16'(i * 7 + 3), 32'(i + 100), 3'(i + 4), 3'd2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd2, 3'd4);
    for (int i = 0; i < 300; i++) rand_cycle();
    // Asynchronous reset between a capture and its write edge.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 16'h7777, 32'h50, 3'd6, 3'd6);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    q.push_back(snap(3'd6, 3'd6));
    ->async_ev;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd6, 3'd6);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd6, 3'd6);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 16'h4242, 32'h60, 3'd7, 3'd6);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd7, 3'd6);
    // Retired counter wrap: reset, 65535 captures, then one more.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd0, 3'd0);
    for (int i = 0; i < 65535; i++)
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'(i), 16'(i), 32'(i * 4), 3'(i + 1), 3'(i));
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'hFACE, 32'hFFFF_FFFC, 3'd1, 3'd2);
    for (int i = 0; i < 50; i++) rand_cycle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0, 3'd0, 3'd0);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
